// File: rtl/sin_burst_ctrl.sv
// sin_burst_ctrl: burst/gap sequencer for a sine LUT, emitting table index, enable and period count.
module sin_burst_ctrl #(
   parameter int LUT_LEN = 48,
   parameter int IDX_W = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             STOP,
   input  logic [2:0]       STEP,
   input  logic [7:0]       NCYC,
   input  logic [7:0]       GAP,
   input  logic             REPEAT,
   output logic [IDX_W-1:0] LUT_IDX,
   output logic             LUT_EN,
   output logic             BUSY,
   output logic             DONE,
   output logic [7:0]       CYC_CNT
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;
   localparam logic [IDX_W:0] LEN = (IDX_W+1)'(LUT_LEN);
   state_t state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d, gap_cnt_q, gap_cnt_d, ncyc_q, ncyc_d, gap_q, gap_d;
   logic [2:0] step_q, step_d;
   logic rep_q, rep_d, stop_pend_q, stop_pend_d, done_q, done_d;
   logic [IDX_W:0] sum;
   logic [7:0] cnt_inc;
   logic wrap, last;
   assign sum = {1'b0, idx_q} + {{(IDX_W-2){1'b0}}, step_q};
   assign wrap = sum >= LEN;
   assign cnt_inc = cnt_q + 8'd1;
   assign last = wrap && ((ncyc_q != 8'd0 && cnt_inc == ncyc_q) || stop_pend_q);
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      gap_cnt_d = gap_cnt_q;
      ncyc_d = ncyc_q;
      gap_d = gap_q;
      step_d = step_q;
      rep_d = rep_q;
      stop_pend_d = stop_pend_q;
      done_d = 1'b0;
      case (state_q)
         S_IDLE: if (START) begin
            state_d = S_RUN;
            idx_d = '0;
            cnt_d = 8'd0;
            stop_pend_d = 1'b0;
            step_d = STEP == 3'd0 ? 3'd1 : STEP;
            ncyc_d = NCYC;
            gap_d = GAP;
            rep_d = REPEAT;
         end
         S_RUN: begin
            stop_pend_d = stop_pend_q | STOP;
            idx_d = wrap ? IDX_W'(sum - LEN) : IDX_W'(sum);
            cnt_d = wrap ? cnt_inc : cnt_q;
            // a burst only ends on a wrap, so the residual phase is dropped and the next burst starts at 0
            if (last) begin
               idx_d = '0;
               if (!stop_pend_q && gap_q != 8'd0) begin
                  state_d = S_GAP;
                  gap_cnt_d = gap_q;
               end else if (!stop_pend_q && rep_q) begin
                  cnt_d = 8'd0;
               end else begin
                  state_d = S_IDLE;
                  done_d = 1'b1;
               end
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - 8'd1;
            if (STOP || (gap_cnt_q == 8'd1 && (!rep_q || stop_pend_q))) begin
               state_d = S_IDLE;
               done_d = 1'b1;
            end else if (gap_cnt_q == 8'd1) begin
               state_d = S_RUN;
               cnt_d = 8'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q <= '0;
         cnt_q <= 8'd0;
         gap_cnt_q <= 8'd0;
         ncyc_q <= 8'd0;
         gap_q <= 8'd0;
         step_q <= 3'd1;
         rep_q <= 1'b0;
         stop_pend_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         gap_cnt_q <= gap_cnt_d;
         ncyc_q <= ncyc_d;
         gap_q <= gap_d;
         step_q <= step_d;
         rep_q <= rep_d;
         stop_pend_q <= stop_pend_d;
         done_q <= done_d;
      end
   end
   assign LUT_IDX = idx_q;
   assign LUT_EN = state_q == S_RUN;
   assign BUSY = state_q != S_IDLE;
   assign DONE = done_q;
   assign CYC_CNT = cnt_q;
endmodule

// File: doc/sin_burst_ctrl.md
# sin_burst_ctrl

Sequencer for the 48-entry sine lookup datapath. It generates the table index, an output-enable, and a burst/gap schedule, replacing the free-running modulo-48 counter. The host requests bursts of N sine periods with a programmable phase step (frequency multiplier), an optional zero gap, and optional auto-repeat. Downstream logic drives the sine output to 0 whenever LUT_EN is low.

## Interface
- LUT_LEN, 48, number of table entries (index range 0..LUT_LEN-1)
- IDX_W, 6, width of the table index
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- START  input  1  one-cycle request; sampled only in IDLE
- STOP  input  1  one-cycle abort request; sampled only while BUSY
- STEP  input  3  phase increment per sample; 0 treated as 1
- NCYC  input  8  periods per burst; 0 = continuous until STOP
- GAP  input  8  zero-output samples between bursts; 0 = no gap
- REPEAT  input  1  1 = restart burst after gap, 0 = single burst
- LUT_IDX  output  IDX_W  table index to sine LUT
- LUT_EN  output  1  1 = LUT_IDX valid, sine output live
- BUSY  output  1  high in RUN or GAP
- DONE  output  1  one-cycle pulse on return to IDLE
- CYC_CNT  output  8  completed periods in the current burst

## Operation
- States: IDLE, RUN, GAP.
- IDLE: LUT_EN=0, LUT_IDX=0, BUSY=0. On START, latch STEP (0->1), NCYC, GAP, REPEAT into shadow registers; clear CYC_CNT, clear stop_pend, go to RUN with LUT_IDX=0. Inputs other than START/STOP are ignored after latch.
- RUN: LUT_EN=1; each cycle sum = LUT_IDX + step (IDX_W+1 bits). If sum >= LUT_LEN it is a wrap: LUT_IDX = sum - LUT_LEN (residual phase kept) and CYC_CNT increments (8-bit, wraps 255->0 in continuous mode). Otherwise LUT_IDX = sum.
- Burst end on a wrap when (NCYC!=0 and CYC_CNT+1==NCYC) or stop_pend:
  - stop_pend: go to IDLE, DONE=1, no gap.
  - else GAP>0: go to GAP, LUT_IDX=0, gap counter loaded with GAP.
  - else GAP=0 and REPEAT=1: stay in RUN, LUT_IDX=0, CYC_CNT=0.
  - else: go to IDLE, DONE=1.
- GAP: LUT_EN=0, LUT_IDX=0; counter decrements each cycle. After GAP cycles: REPEAT=1 and no stop_pend -> RUN with CYC_CNT=0; otherwise IDLE with DONE=1.
- STOP while BUSY: in RUN, set stop_pend; the burst ends at the next wrap, so no partial period is output. In GAP, go to IDLE next cycle with DONE=1. STOP in IDLE is ignored.
- START while BUSY is ignored, with no queuing. If START and STOP arrive together in IDLE, START is taken and STOP is dropped.

## Timing
- Reset values: LUT_IDX=0, LUT_EN=0, BUSY=0, DONE=0, CYC_CNT=0, state IDLE, stop_pend=0. RST mid-burst forces these values at the next edge. The output returns to 0 with no final DONE pulse.
- Latency: START at edge t gives RUN at t+1 with LUT_IDX=0, LUT_EN=1, BUSY=1.
- One table sample per cycle in RUN. The period length is LUT_LEN/step cycles, which is non-integer for steps that do not divide 48.
- DONE is registered and asserted in the first IDLE cycle, together with BUSY=0. A new START is accepted in that same cycle.
- A GAP of G produces exactly G cycles with LUT_EN=0 between the last burst sample and the next LUT_IDX=0 sample.

## Test plan
- STEP=1, NCYC=1, GAP=0, REPEAT=0, START at cycle 0:
  - LUT_EN=1 in cycles 1..48 with LUT_IDX 0..47.
  - Cycle 49: DONE=1, BUSY=0, CYC_CNT=1.
- STEP=5, NCYC=2:
  - LUT_IDX sequence 0,5,...,45,2,7,...; the wrap 45->2 sets CYC_CNT=1.
  - The second wrap ends the burst; DONE the next cycle.
- STEP=2, NCYC=1, GAP=3, REPEAT=1:
  - 24 samples (0..46), then 3 cycles with LUT_EN=0, then LUT_IDX=0 again with CYC_CNT=0.
  - Verify over 3 bursts.
- NCYC=0, STEP=1:
  - Run 200 cycles; pulse STOP at LUT_IDX=10.
  - Output continues through LUT_IDX=47, then IDLE and DONE. No gap even if GAP=5.
- START during RUN and STOP during GAP:
  - START is ignored and the parameters stay unchanged.
  - STOP in GAP gives DONE the next cycle.
  - START+STOP together in IDLE starts a burst.
- RST asserted at LUT_IDX=20 in RUN: next cycle all outputs at reset values, DONE=0. A following START behaves as in test 1.
